// File: rtl/inst_fetch.sv
// RV32I instruction fetch: owns the PC, issues imem word requests, buffers {pc, inst} in order for decode.
// Latency: one cycle from imem_rvalid to inst_valid; no bypass. Optional IFETCH_PERF_CNT_EN adds fetch_bubble_cnt.
// Backpressure: requests are credit-limited so buffered + in-flight never exceeds DEPTH; inst_ready stalls the head.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_bubble_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [31:0]   tag_pc [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [31:0]   fifo_pc  [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [31:0]   fifo_pc_nxt  [DEPTH];
    logic [31:0]   fifo_dat_nxt [DEPTH];

    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] wr_idx;
    logic [CW:0]   credit_used;

    assign credit_used  = {1'b0, count} + {1'b0, inflight};
    assign imem_req     = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign grant        = imem_req && imem_gnt;
    // A response with nothing outstanding is a bus protocol error and is dropped entirely.
    assign rsp          = imem_rvalid && (inflight != '0);
    assign push         = rsp && (discard == '0) && !redirect_valid;
    assign pop          = inst_valid && inst_ready;
    assign inflight_nxt = inflight + CW'(grant) - CW'(rsp);

    assign inst_valid = (count != '0);
    assign inst       = fifo_dat[0];
    assign inst_pc    = fifo_pc[0];

    // Shift-register buffer: entry 0 is always the head, so the outputs come straight from flops.
    always_comb begin
        wr_idx = pop ? (count - CW'(1)) : count;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_nxt[i]  = fifo_pc[i];
            fifo_dat_nxt[i] = fifo_dat[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_pc_nxt[i]  = fifo_pc[i+1];
                fifo_dat_nxt[i] = fifo_dat[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    fifo_pc_nxt[i]  = tag_pc[tag_rd];
                    fifo_dat_nxt[i] = imem_rdata;
                end
            end
        end
        if (redirect_valid) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_pc[i]   <= '0;
                fifo_pc[i]  <= '0;
                fifo_dat[i] <= '0;
            end
        end else begin
            if (grant) begin
                tag_pc[tag_wr] <= fetch_pc;
                tag_wr         <= tag_wr + PW'(1);
            end
            if (rsp) begin
                tag_rd <= tag_rd + PW'(1);
            end
            inflight <= inflight_nxt;
            count    <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]  <= fifo_pc_nxt[i];
                fifo_dat[i] <= fifo_dat_nxt[i];
            end
            // Everything still outstanding after this cycle belongs to the old path.
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                discard  <= inflight_nxt;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_bubble_cnt <= '0;
        end else if (inst_ready && !inst_valid && (fetch_bubble_cnt != 32'hFFFF_FFFF)) begin
            fetch_bubble_cnt <= fetch_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: imem bus model, spec-level counter model and a PC-stream scoreboard.
module tb_inst_fetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam int          NCYC  = 6000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_bubble_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_bubble_cnt (fetch_bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;

    int          m_out;
    int          m_buf;
    int          m_disc;
    logic [31:0] m_fetch;
    logic [31:0] next_pc;
    int          last_due;
    int          bub;
    bit          just_reset;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every instruction decode accepts must be the next PC of the current stream.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 && redirect_valid === 1'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got pc %h expected no instruction", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst", inst, mem_word(e));
                n_acc++;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        m_out = 0; m_buf = 0; m_disc = 0; m_fetch = RPC; next_pc = RPC;
        last_due = 0; bub = 0; just_reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int ph;
            @(posedge clk);
            #1;
            ph    = (cyc / 500) % 4;
            rst_n = !((cyc < 3) || (cyc >= 2000 && cyc < 2002) || (cyc == 4000));
            if (rst_n) begin
                redirect_valid = ($urandom_range(0, 39) == 0);
                case ($urandom_range(0, 2))
                    0:       redirect_pc = 32'h0000_2003;
                    1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: redirect_pc = $urandom;
                endcase
                imem_gnt   = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                inst_ready = (ph == 1) ? ($urandom_range(0, 7) == 0) :
                             (ph == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(r.addr);
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    next_pc = {redirect_pc[31:2], 2'b00};
                end
            end else begin
                redirect_valid = 1'b0;
                imem_gnt       = 1'b0;
                imem_rvalid    = 1'b0;
                inst_ready     = 1'b0;
                rsp_q.delete();
                exp_q.delete();
                next_pc = RPC;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end

            @(negedge clk);
            if (!rst_n) begin
                check("req_in_reset", {31'b0, imem_req}, 32'd0);
                m_out = 0; m_buf = 0; m_disc = 0; m_fetch = RPC;
                last_due = 0; bub = 0; just_reset = 1'b1;
            end else begin
                bit exp_req, g, rsp, pop;
                int out_next;
                exp_req = !redirect_valid && (m_out + m_buf < DEPTH);
                check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
                check("imem_addr", imem_addr, m_fetch);
                check("inst_valid", {31'b0, inst_valid}, {31'b0, (m_buf > 0)});
                if (just_reset) begin
                    check("inst_after_reset", inst, 32'd0);
                    check("inst_pc_after_reset", inst_pc, 32'd0);
                    just_reset = 1'b0;
                end
`ifdef IFETCH_PERF_CNT_EN
                check("fetch_bubble_cnt", fetch_bubble_cnt, 32'(bub));
                if (inst_ready && m_buf == 0) bub++;
`endif
                g   = exp_req && imem_gnt;
                rsp = imem_rvalid && (m_out > 0);
                pop = inst_ready && (m_buf > 0);
                if (g) begin
                    rsp_t r;
                    r.addr = m_fetch;
                    r.due  = cyc + 1 + $urandom_range(0, 2);
                    if (r.due < last_due) r.due = last_due;
                    last_due = r.due;
                    rsp_q.push_back(r);
                end
                out_next = m_out + int'(g) - int'(rsp);
                if (redirect_valid) begin
                    m_buf   = 0;
                    m_disc  = out_next;
                    m_fetch = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (rsp) begin
                        if (m_disc > 0) m_disc--;
                        else m_buf++;
                    end
                    if (pop) m_buf--;
                    if (g) m_fetch = m_fetch + 32'd4;
                end
                m_out = out_next;
            end
        end

        @(posedge clk);
        n_chk++;
        if (n_acc < 200) begin
            n_fail++;
            $display("FAIL progress: got %0d accepted instructions expected at least 200", n_acc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
